// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host receiver: synchronises PS2_CLK/PS2_DAT, deframes 11-bit frames, decodes E0/F0 prefixes.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity; otherwise the parity bit is ignored.
module ps2_frame_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev, fe, dat;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic [TW-1:0]          tcnt;
  logic                   timeout, frame_good, frame_bad;
  logic                   ext_flag, brk_flag;
`ifdef PS2_PARITY_CHECK_EN
  logic                   par_bit;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fe  = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign dat = dat_sync[SYNC_STAGES-1];

  // Fires on the edge where the counter would reach TIMEOUT_CYCLES-1.
  assign timeout = (state != IDLE) && !fe && (tcnt == TW'(TIMEOUT_CYCLES - 2));

`ifdef PS2_PARITY_CHECK_EN
  assign frame_good = fe && (state == STOP) && dat && (^{shift, par_bit});
`else
  assign frame_good = fe && (state == STOP) && dat;
`endif
  assign frame_bad = (fe && (state == STOP) && !frame_good) || timeout;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fe && !dat)            state_next = DATA;
      DATA:    if (fe && bit_cnt == 3'd7) state_next = PARITY;
      PARITY:  if (fe)                    state_next = STOP;
      STOP:    if (fe)                    state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
    if (timeout) state_next = IDLE;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bit_cnt   <= '0;
      shift     <= '0;
      tcnt      <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      key_code  <= '0;
      key_break <= 1'b0;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      if (fe || state == IDLE) tcnt <= '0;
      else                     tcnt <= tcnt + TW'(1);

      if (fe) begin
        case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shift   <= {dat, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
`ifdef PS2_PARITY_CHECK_EN
          PARITY: par_bit <= dat;
`endif
          default: ;
        endcase
      end

      rx_valid  <= frame_good;
      frame_err <= frame_bad;
      if (frame_good) rx_byte <= shift;

      key_valid <= 1'b0;
      if (rx_valid) begin
        if (rx_byte == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk_flag <= 1'b1;
        end else begin
          key_code  <= rx_byte;
          key_ext   <= ext_flag;
          key_break <= brk_flag;
          key_valid <= 1'b1;
          ext_flag  <= 1'b0;
          brk_flag  <= 1'b0;
        end
      end else if (frame_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed + randomized bench for ps2_frame_rx with a transaction-level reference model.
module tb_ps2_frame_rx;

  localparam int unsigned TO   = 200;
  localparam int unsigned SYNC = 2;
  localparam int          HALF = 20;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] rx_byte, key_code;
  logic       rx_valid, key_break, key_ext, key_valid, frame_err;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
    .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .key_code(key_code),
    .key_break(key_break), .key_ext(key_ext), .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Event capture
  logic [7:0] rx_b_q[$];
  int         rx_t_q[$];
  logic [9:0] key_q[$];
  int         key_t_q[$];
  int         err_t_q[$];
  bit         overlap_seen = 1'b0;
  bit         double_key_seen = 1'b0;
  logic       key_prev = 1'b0;

  always @(negedge clock) begin
    if (rx_valid) begin rx_b_q.push_back(rx_byte); rx_t_q.push_back(cyc); end
    if (key_valid) begin key_q.push_back({key_ext, key_break, key_code}); key_t_q.push_back(cyc); end
    if (frame_err) err_t_q.push_back(cyc);
    if (rx_valid && frame_err) overlap_seen = 1'b1;
    if (key_valid && key_prev) double_key_seen = 1'b1;
    key_prev = key_valid;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: keyboard-level state
  logic [7:0] m_rx = '0, m_code = '0;
  bit         m_kbrk = 0, m_kext = 0, m_ext = 0, m_brk = 0;
  int         last_fall = 0;

  task automatic clear_q();
    rx_b_q.delete(); rx_t_q.delete(); key_q.delete(); key_t_q.delete(); err_t_q.delete();
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (HALF) @(posedge clock);
    #1 ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(posedge clock);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic check_holds();
    chk("rx_byte_hold", 32'(rx_byte), 32'(m_rx));
    chk("key_code_hold", 32'(key_code), 32'(m_code));
    chk("key_break_hold", 32'(key_break), 32'(m_kbrk));
    chk("key_ext_hold", 32'(key_ext), 32'(m_kext));
  endtask

  task automatic run_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    bit   good;
    int   exp_keys;
    logic par;
    clear_q();
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    ps2_dat = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    good = !bad_stop && !(bad_par && PCHK);
    exp_keys = 0;
    if (good) begin
      chk("rx_count", 32'(rx_b_q.size()), 32'd1);
      chk("err_count_good", 32'(err_t_q.size()), 32'd0);
      if (rx_b_q.size() > 0) begin
        chk("rx_data", 32'(rx_b_q[0]), 32'(b));
        chk("rx_latency", 32'(rx_t_q[0] - last_fall), 32'(SYNC + 1));
      end
      m_rx = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        m_code = b; m_kext = m_ext; m_kbrk = m_brk;
        m_ext = 0; m_brk = 0;
        exp_keys = 1;
      end
    end else begin
      chk("err_count_bad", 32'(err_t_q.size()), 32'd1);
      chk("rx_count_bad", 32'(rx_b_q.size()), 32'd0);
      if (err_t_q.size() > 0) chk("err_latency", 32'(err_t_q[0] - last_fall), 32'(SYNC + 1));
      m_ext = 0; m_brk = 0;
    end
    chk("key_count", 32'(key_q.size()), 32'(exp_keys));
    if (exp_keys == 1 && key_q.size() > 0) begin
      chk("key_event", 32'(key_q[0]), 32'({m_kext, m_kbrk, m_code}));
      if (rx_t_q.size() > 0) chk("key_delay", 32'(key_t_q[0] - rx_t_q[0]), 32'd1);
    end
    check_holds();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_byte"}, 32'(rx_byte), 32'd0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_key_code"}, 32'(key_code), 32'd0);
    chk({tag, "_key_break"}, 32'(key_break), 32'd0);
    chk({tag, "_key_ext"}, 32'(key_ext), 32'd0);
    chk({tag, "_key_valid"}, 32'(key_valid), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int         sel;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock); #1 resetn = 1'b1;
    repeat (5) @(posedge clock); #1;

    // Plain make, break, extended break, follow-up make
    run_frame(8'h1C, 0, 0);
    run_frame(8'hF0, 0, 0);
    run_frame(8'h1C, 0, 0);
    run_frame(8'hE0, 0, 0);
    run_frame(8'hF0, 0, 0);
    run_frame(8'h75, 0, 0);
    run_frame(8'h1C, 0, 0);

    // Bad parity, bad stop
    run_frame(8'h1C, 1, 0);
    run_frame(8'h1C, 0, 1);

    // Prefix then timeout: flags must be dropped
    run_frame(8'hE0, 0, 0);
    clear_q();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(1)));
    ps2_dat = 1'b1;
    repeat (TO + 30) @(posedge clock);
    #1;
    chk("timeout_err_count", 32'(err_t_q.size()), 32'd1);
    if (err_t_q.size() > 0) chk("timeout_latency", 32'(err_t_q[0] - last_fall), 32'(SYNC + TO));
    chk("timeout_rx_count", 32'(rx_b_q.size()), 32'd0);
    chk("timeout_key_count", 32'(key_q.size()), 32'd0);
    m_ext = 0; m_brk = 0;
    run_frame(8'h29, 0, 0);

    // Reset mid-frame
    clear_q();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("midreset");
    @(posedge clock); #1 resetn = 1'b1;
    m_rx = '0; m_code = '0; m_kbrk = 0; m_kext = 0; m_ext = 0; m_brk = 0;
    repeat (5) @(posedge clock); #1;
    chk("midreset_pulses", 32'(rx_b_q.size() + key_q.size() + err_t_q.size()), 32'd0);
    run_frame(8'h4A, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 20; n++) begin
      sel = int'($urandom_range(9));
      if (sel == 0)      b = 8'hE0;
      else if (sel == 1) b = 8'hF0;
      else               b = 8'($urandom);
      run_frame(b, $urandom_range(7) == 0, $urandom_range(7) == 0);
    end

    chk("no_rx_err_overlap", 32'(overlap_seen), 32'd0);
    chk("no_back_to_back_key", 32'(double_key_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
